// File: rtl/sync_ram_burst_reader_pkg.sv
// Shared types and sizing helpers for the synchronous-RAM burst reader.
package sync_ram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Number of words addressable with the given address width.
    function automatic int depth_words(input int address_width);
        return 2 ** address_width;
    endfunction

    // Width of an occupancy counter that must hold 0..fifo_depth.
    function automatic int cnt_w(input int fifo_depth);
        return $clog2(fifo_depth) + 1;
    endfunction

    localparam int DEPTH_WORDS = depth_words(10);
    localparam int CNT_W       = cnt_w(4);

endpackage

// File: rtl/sync_ram_burst_reader_if.sv
// Valid/ready output stream of the burst reader.
interface sync_ram_burst_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/sync_ram_rd_fifo.sv
// Small register-based FIFO that absorbs RAM read latency and stream backpressure.
module sync_ram_rd_fifo
    import sync_ram_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int COUNT_W    = cnt_w(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [COUNT_W-1:0]    count,
    output logic                  empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + COUNT_W'(push) - COUNT_W'(pop);
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);

endmodule

// File: rtl/sync_ram_burst_reader.sv
// Burst read engine: issues consecutive RAM reads and streams the words out through a FIFO.
module sync_ram_burst_reader
    import sync_ram_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] ram_address_r,
    input  logic [DATA_WIDTH-1:0]    ram_data_out,
    sync_ram_burst_reader_if.master  m_if
);
    localparam int COUNT_W = cnt_w(FIFO_DEPTH);
    localparam int LEN_W   = ADDRESS_WIDTH + 1;

    state_t                   state, state_next;
    logic [ADDRESS_WIDTH-1:0] issue_addr, issue_addr_next;
    logic [LEN_W-1:0]         issue_left, issue_left_next;
    logic [LEN_W-1:0]         beats_left, beats_left_next;
    logic [1:0]               inflight, inflight_next;
    logic [COUNT_W-1:0]       fifo_count, fifo_count_next;
    logic                     issue_q, issue_next;
    logic                     push_q;
    logic                     pop;
    logic                     fifo_empty;
    logic [DATA_WIDTH-1:0]    head_data;

    sync_ram_rd_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_q),
        .push_data(ram_data_out),
        .pop      (pop),
        .head_data(head_data),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (length == '0) ? FINISH : RUN;
            RUN:     if (pop && beats_left == LEN_W'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        done         = (state == FINISH);
        pop          = !fifo_empty && m_if.m_ready;
        m_if.m_valid = !fifo_empty;
        m_if.m_data  = head_data;
    end

    // The issue decision for the next cycle is made from next-cycle counts so that
    // ram_address_r can be a plain register that already holds the address when the read happens.
    always_comb begin
        issue_addr_next = issue_addr;
        issue_left_next = issue_left;
        beats_left_next = beats_left;
        if (state == IDLE && start) begin
            issue_addr_next = base_addr;
            issue_left_next = length;
            beats_left_next = length;
        end else begin
            if (issue_q) begin
                issue_addr_next = issue_addr + ADDRESS_WIDTH'(1);
                issue_left_next = issue_left - LEN_W'(1);
            end
            if (pop) beats_left_next = beats_left - LEN_W'(1);
        end
        fifo_count_next = fifo_count + COUNT_W'(push_q) - COUNT_W'(pop);
        inflight_next   = inflight + 2'(issue_q) - 2'(push_q);
        issue_next      = (state_next == RUN) && (issue_left_next != '0) &&
                          (int'(fifo_count_next) + int'(inflight_next) < FIFO_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_addr    <= '0;
            issue_left    <= '0;
            beats_left    <= '0;
            inflight      <= '0;
            issue_q       <= 1'b0;
            push_q        <= 1'b0;
            ram_address_r <= '0;
        end else begin
            issue_addr <= issue_addr_next;
            issue_left <= issue_left_next;
            beats_left <= beats_left_next;
            inflight   <= inflight_next;
            issue_q    <= issue_next;
            // RAM data for the address issued this cycle arrives next cycle and is pushed then.
            push_q     <= issue_q;
            if (issue_next) ram_address_r <= issue_addr_next;
        end
    end

endmodule

// File: tb/tb_sync_ram_burst_reader.sv
// Scoreboard bench for sync_ram_burst_reader against a behavioural 16x8 synchronous RAM.
module tb_sync_ram_burst_reader;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_address_r;
    logic [DW-1:0] ram_data_out;

    sync_ram_burst_reader_if #(.DATA_WIDTH(DW)) s_if ();

    sync_ram_burst_reader #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .ram_address_r(ram_address_r),
        .ram_data_out (ram_data_out),
        .m_if         (s_if)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
    always @(posedge clk) ram_data_out <= mem[ram_address_r];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [DW-1:0] sb [$];
    int            start_cyc;
    int            first_valid_cyc;
    int            last_beat_cyc;
    int            done_cyc;
    int            done_cnt;
    int            beats;
    logic [DW-1:0] last_data;
    logic          credit_chk = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall_hold", {s_if.m_valid, s_if.m_data}, {1'b1, prev_data});
            if (s_if.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (s_if.m_valid && s_if.m_ready) begin
                if (sb.size() == 0) check("spurious_beat", sb.size(), 1);
                else                check("beat", s_if.m_data, sb.pop_front());
                beats++;
                last_beat_cyc = cyc;
                last_data     = s_if.m_data;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (credit_chk) check("credit", int'(dut.fifo_count) + int'(dut.inflight) <= 4, 1);
            prev_stall = s_if.m_valid && !s_if.m_ready;
            prev_data  = s_if.m_data;
        end
    end

    task automatic do_start(input int base, input int len);
        @(posedge clk);
        #1;
        start           = 1'b1;
        base_addr       = AW'(base);
        length          = (AW + 1)'(len);
        start_cyc       = cyc;
        first_valid_cyc = -1;
        beats           = 0;
        done_cnt        = 0;
        for (int i = 0; i < len; i++) sb.push_back(8'hA0 + 8'((base + i) % 16));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt == 0) check("done_timeout", done_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] wrap_addr [4];
        int            n;
        wrap_addr = '{4'd14, 4'd15, 4'd0, 4'd1};

        rst         = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        length      = '0;
        s_if.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", s_if.m_valid, 0);
        check("rst_addr", ram_address_r, 0);
        #1 rst = 1'b0;

        // Basic burst
        do_start(2, 5);
        @(negedge clk);
        check("basic_busy", busy, 1);
        wait_done(100);
        check("basic_latency", first_valid_cyc - start_cyc, 3);
        check("basic_consecutive", last_beat_cyc - first_valid_cyc, 4);
        check("basic_done_cycle", done_cyc, last_beat_cyc + 1);
        check("basic_beats", beats, 5);
        @(negedge clk);
        check("basic_busy_fall", busy, 0);
        repeat (3) @(negedge clk);
        check("basic_done_once", done_cnt, 1);
        check("basic_sb_empty", sb.size(), 0);

        // Address wrap
        do_start(14, 4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("wrap_addr", ram_address_r, wrap_addr[k]);
        end
        wait_done(100);
        check("wrap_beats", beats, 4);
        check("wrap_sb_empty", sb.size(), 0);

        // Backpressure with ready pattern 1,0,0,1
        credit_chk = 1'b1;
        do_start(0, 8);
        n = 0;
        while (done_cnt == 0 && n < 200) begin
            s_if.m_ready = (n % 4 == 0) || (n % 4 == 3);
            @(posedge clk);
            #1;
            n++;
        end
        if (done_cnt == 0) check("bp_done_timeout", done_cnt, 1);
        credit_chk   = 1'b0;
        s_if.m_ready = 1'b1;
        check("bp_beats", beats, 8);
        check("bp_last", last_data, 8'hA7);
        check("bp_sb_empty", sb.size(), 0);

        // Zero length
        do_start(3, 0);
        @(negedge clk);
        check("len0_done_cycle1", done, 1);
        repeat (4) @(negedge clk);
        check("len0_no_valid", first_valid_cyc, -1);
        check("len0_done_once", done_cnt, 1);

        // Full-depth burst from base 5
        do_start(5, 16);
        wait_done(200);
        check("full_beats", beats, 16);
        check("full_last", last_data, 8'hA4);
        check("full_sb_empty", sb.size(), 0);

        // Start reasserted during RUN is ignored
        do_start(2, 6);
        #1;
        start     = 1'b1;
        base_addr = 4'd9;
        length    = 5'd3;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        wait_done(100);
        repeat (4) @(negedge clk);
        check("restart_beats", beats, 6);
        check("restart_done_once", done_cnt, 1);
        check("restart_sb_empty", sb.size(), 0);

        // Reset at beat 3 of an 8-beat burst
        do_start(0, 8);
        n = 0;
        while (beats < 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_mid_reached", beats, 3);
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", s_if.m_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid_no_done", done_cnt, 0);
        check("rst_mid_no_valid", s_if.m_valid, 0);

        // Clean burst after the reset
        do_start(9, 3);
        wait_done(100);
        check("post_rst_latency", first_valid_cyc - start_cyc, 3);
        check("post_rst_beats", beats, 3);
        check("post_rst_last", last_data, 8'hAB);
        check("post_rst_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_ram_burst_reader.md
Name: sync_ram_burst_reader

Overview:
Read-side engine for the block-RAM test designs. It drives the read-address port of a synchronous simple-dual-port RAM, which has 1-cycle registered read latency and reads every cycle with no enable. It streams a burst of consecutive words out on a valid/ready interface.
- Latency and backpressure are absorbed by a small output FIFO.
- Sustains one word per cycle when downstream is always ready.
- Gives the inference tests a realistic consumer for RAMs filled by a writer.

Parameters:
- DATA_WIDTH, 8, RAM word width and stream data width.
- ADDRESS_WIDTH, 10, RAM address width; depth is 2**ADDRESS_WIDTH.
- FIFO_DEPTH, 4, output buffer entries; power of two, minimum 4.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin burst; sampled only while idle.
- base_addr  in  ADDRESS_WIDTH  first word address.
- length  in  ADDRESS_WIDTH+1  word count, 0..2**ADDRESS_WIDTH.
- busy  out  1  high from the cycle after an accepted start until the cycle done is high, inclusive.
- done  out  1  single-cycle pulse at burst completion.
- ram_address_r  out  ADDRESS_WIDTH  RAM read address, driven from a register.
- ram_data_out  in  DATA_WIDTH  RAM registered read data.
- m_data  out  DATA_WIDTH  stream data (FIFO head).
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.

Behaviour:
- Reset: busy=0, done=0, m_valid=0, ram_address_r=0, FIFO empty, in-flight tracking cleared. m_data is don't-care while m_valid=0.
- Reset mid-burst: everything is discarded; no done pulse; reads still in flight are dropped.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 latches base_addr and length.
  - length=0 goes to FINISH.
  - Any other length goes to RUN, with issue_addr=base_addr, issue_left=length, beats_left=length.
- RUN, issue rule:
  - Issue when issue_left>0 and fifo_count+inflight < FIFO_DEPTH, evaluated on registered counts.
  - An issue cycle sets ram_address_r=issue_addr for that cycle, then increments issue_addr modulo 2**ADDRESS_WIDTH and decrements issue_left.
- RAM data timing: data for an address held in cycle C appears on ram_data_out in cycle C+1. It is pushed into the FIFO at the end of C+1 and is visible on m_data in C+2.
- inflight: 0..2; counts issued reads not yet pushed.
- Latency: start high in cycle 0 gives the first issue in cycle 1 and the first m_valid in cycle 3.
- Throughput: with m_ready held high, one beat per cycle thereafter.
- Stream handshake:
  - A beat transfers when m_valid&m_ready.
  - m_data and m_valid are stable while m_valid=1 and m_ready=0.
  - Beats leave in address order.
  - The FIFO may push and pop in the same cycle; count is unchanged.
  - The FIFO never overflows, guaranteed by the issue rule.
- RUN exit: the transfer of the last beat (beats_left 1→0) moves to FINISH.
- FINISH: done=1 for one cycle, then IDLE. busy is high in FINISH.
- start while busy is ignored. start in the FINISH cycle is also ignored; it is accepted the following cycle at the earliest.
- Address wrap: base_addr+length beyond depth wraps to 0. length=2**ADDRESS_WIDTH reads every word exactly once.
- ram_address_r in non-issue cycles holds its last value. Its value is irrelevant to correctness.

Decomposition:
- Package sync_ram_pkg:
  - state enum (IDLE/RUN/FINISH);
  - localparam helpers DEPTH_WORDS = 2**ADDRESS_WIDTH and CNT_W = $clog2(FIFO_DEPTH)+1.
- Sub-module sync_ram_rd_fifo:
  - parameters DATA_WIDTH and FIFO_DEPTH;
  - ports: push/push_data, pop/head_data, count, empty;
  - synchronous reset, register-based storage;
  - head_data is registered-read-free, i.e. combinational from storage.
- The top level holds the FSM, the issue/credit counters and the address counter.

Test Plan:
Bench setup: DATA_WIDTH=8, ADDRESS_WIDTH=4, paired with a behavioural SDP RAM preloaded with mem[i]=8'hA0+i.
- Basic burst: start, base=2, length=5, m_ready=1 → m_valid first high 3 cycles after start; beats A2,A3,A4,A5,A6 on consecutive cycles; done pulses once in the cycle after the last beat; busy then falls.
- Wrap: base=14, length=4 → beats AE,AF,A0,A1; ram_address_r sequence 14,15,0,1.
- Backpressure: base=0, length=8, m_ready toggling 1,0,0,1,... → exactly A0..A7 in order with no loss or duplication; m_data stable during stalls; fifo_count+inflight never exceeds 4.
- Edge lengths:
  - length=0 → done pulses cycle 1, no m_valid.
  - length=16, base=5 → all 16 words, A5 first, A4 last.
- Start and reset interactions:
  - start reasserted during RUN with base=9 → ignored; the original burst completes unchanged.
  - rst asserted at beat 3 of an 8-beat burst → next cycle m_valid=0, busy=0, no done pulse.
  - New start after that reset → clean burst from its base.
